// File: rtl/imem_boot_loader_if.sv
// Byte-receive and instruction-memory write bus of the boot loader.
//
// Handshake: rx_valid is a one-cycle strobe that qualifies rx_data in the
// same cycle. There is no ready: the loader accepts a byte on every cycle,
// including back-to-back. wr_en is a one-cycle strobe that qualifies
// wr_addr/wr_data in the same cycle. The memory has no ready either and must
// take the write in that cycle.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // Byte source and memory sink side
  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_addr, wr_data
  );

  // Loader side
  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Serial program loader.
// Frame: 0xA5, word count N (LE16), 4*N data bytes (LE words), checksum byte.
// Writes words from address 0 and keeps the core in reset until the frame
// checksum matches. dbg_state exposes the FSM state encoding.
module imem_boot_loader #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 100000
) (
  input  logic                 CLOCK,
  input  logic                 RST_n,
  input  logic                 reload,
  imem_boot_loader_if.slave    bus,
  output logic                 core_RST_n,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           dbg_state
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_word;
  logic [7:0]        csum;
  logic [IDLE_W-1:0] idle_cnt;
  logic [15:0]       len_word;
  logic              in_frame;

  assign len_word  = {bus.rx_data, len_lo};
  assign in_frame  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CHECK);
  assign dbg_state = state;

  // Frame FSM with registered outputs, idle timeout and write sequencing
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= S_SYNC;
      len_lo      <= '0;
      word_cnt    <= '0;
      byte_idx    <= '0;
      asm_word    <= '0;
      csum        <= '0;
      idle_cnt    <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      core_RST_n  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;

      // Advance the address after a write unless that was the frame's last
      // word, so a full DEPTH-word load never wraps back to 0.
      if (bus.wr_en && (word_cnt != 16'd0)) begin
        bus.wr_addr <= bus.wr_addr + 1'b1;
      end

      if (in_frame && !bus.rx_valid) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end

      case (state)
        S_SYNC: begin
          if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            state       <= S_LEN_LO;
            err         <= 1'b0;
            csum        <= '0;
            byte_idx    <= '0;
            bus.wr_addr <= '0;
          end
        end

        S_LEN_LO: begin
          if (bus.rx_valid) begin
            len_lo <= bus.rx_data;
            state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (bus.rx_valid) begin
            if ((len_word == 16'd0) || ({1'b0, len_word} > 17'(DEPTH))) begin
              state <= S_ERROR;
              err   <= 1'b1;
            end else begin
              word_cnt <= len_word;
              state    <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (bus.rx_valid) begin
            asm_word <= {bus.rx_data, asm_word[31:8]};
            csum     <= csum + bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.wr_en   <= 1'b1;
              bus.wr_data <= {bus.rx_data, asm_word[31:8]};
              byte_idx    <= 2'd0;
              word_cnt    <= word_cnt - 16'd1;
              if (word_cnt == 16'd1) begin
                state <= S_CHECK;
              end
            end
          end
        end

        S_CHECK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == csum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_RST_n <= 1'b1;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (reload) begin
            state      <= S_SYNC;
            done       <= 1'b0;
            core_RST_n <= 1'b0;
          end
        end

        S_ERROR: begin
          if (reload) begin
            state <= S_SYNC;
            err   <= 1'b0;
          end else if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
            state       <= S_LEN_LO;
            err         <= 1'b0;
            csum        <= '0;
            byte_idx    <= '0;
            bus.wr_addr <= '0;
          end
        end

        default: state <= S_SYNC;
      endcase

      // Idle timeout overrides whatever the frame states decided
      if (in_frame && !bus.rx_valid && (idle_cnt == IDLE_LAST)) begin
        state <= S_ERROR;
        err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames from the test plan plus random
// frames, checked against a frame-level reference model.
module tb_imem_boot_loader;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;

  typedef logic [7:0] bq_t[$];

  logic       CLOCK = 1'b0;
  logic       RST_n = 1'b0;
  logic       reload = 1'b0;
  logic       core_RST_n;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  int chk_count = 0;
  int err_count = 0;
  bit cur_done  = 1'b0;

  logic [ADDR_W+31:0] exp_q[$];

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLOCK      (CLOCK),
    .RST_n      (RST_n),
    .reload     (reload),
    .bus        (bus),
    .core_RST_n (core_RST_n),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 CLOCK = ~CLOCK;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected word
  always @(negedge CLOCK) begin
    if (RST_n && (bus.wr_en === 1'b1)) begin
      check("wr_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("wr_word", 64'({bus.wr_addr, bus.wr_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Reference model: parse a frame and queue the writes it must produce
  task automatic model(input bq_t q, output bit exp_done, output bit exp_err, output bit exp_to);
    int i, n, nb;
    logic [7:0]  sum;
    logic [31:0] w;
    i = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_to   = 1'b0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    n = int'({q[i+2], q[i+1]});
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    nb  = q.size() - i - 3;
    sum = 8'd0;
    for (int j = 0; j < nb && j < 4 * n; j++) sum += q[i+3+j];
    for (int k = 0; k < n && 4 * k + 3 < nb; k++) begin
      w = {q[i+6+4*k], q[i+5+4*k], q[i+4+4*k], q[i+3+4*k]};
      exp_q.push_back({ADDR_W'(k), w});
    end
    if (nb == 4 * n + 1) begin
      exp_done = (q[q.size()-1] == sum);
      exp_err  = !exp_done;
    end else begin
      exp_err = 1'b1;
      exp_to  = 1'b1;
    end
  endtask

  // Driver: bytes with random 0..3 idle cycles between them
  task automatic send(input bq_t q);
    int gap;
    for (int k = 0; k < q.size(); k++) begin
      bus.rx_data  = q[k];
      bus.rx_valid = 1'b1;
      @(negedge CLOCK);
      gap = $urandom_range(0, 3);
      if (gap != 0 && k != q.size() - 1) begin
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge CLOCK);
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  // mode 0: good checksum, 1: bad checksum, 2: truncated inside data
  task automatic make_frame(input int n, input int mode, output bq_t q);
    logic [7:0] sum;
    int keep;
    q = {};
    q.push_back(8'hA5);
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    sum = 8'd0;
    for (int k = 0; k < 4 * n; k++) begin
      q.push_back(8'($urandom_range(0, 255)));
      sum += q[q.size()-1];
    end
    if (mode == 2) begin
      keep = $urandom_range(1, 4 * n - 1);
      while (q.size() > 3 + keep) void'(q.pop_back());
    end else if (mode == 1) begin
      q.push_back(sum + 8'($urandom_range(1, 255)));
    end else begin
      q.push_back(sum);
    end
  endtask

  task automatic run_frame(input bq_t q, input string tag);
    bit ed, ee, et;
    model(q, ed, ee, et);
    send(q);
    if (!et) begin
      check({tag, "_done"}, 64'(done), 64'(ed));
      check({tag, "_err"},  64'(err),  64'(ee));
      check({tag, "_core"}, 64'(core_RST_n), 64'(ed));
    end else begin
      repeat (TIMEOUT - 1) @(negedge CLOCK);
      check({tag, "_to_early"}, 64'(err), 64'd0);
      @(negedge CLOCK);
      check({tag, "_to_err"},  64'(err), 64'd1);
      check({tag, "_to_core"}, 64'(core_RST_n), 64'd0);
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    cur_done = ed;
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge CLOCK);
    reload = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_core"}, 64'(core_RST_n), 64'd0);
    cur_done = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_en"},   64'(bus.wr_en),   64'd0);
    check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
    check({tag, "_core"},    64'(core_RST_n),  64'd0);
    check({tag, "_done"},    64'(done),        64'd0);
    check({tag, "_err"},     64'(err),         64'd0);
  endtask

  initial begin
    bq_t q;
    int  n, mode, ng;
    logic [7:0] g;

    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;

    // Reset
    repeat (3) @(negedge CLOCK);
    check_reset("rst");
    RST_n = 1'b1;
    @(negedge CLOCK);

    // Two-word valid load
    q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    run_frame(q, "load2");

    // Bytes in DONE are ignored
    for (int k = 0; k < 4; k++) begin
      bus.rx_data  = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      bus.rx_valid = 1'b1;
      @(negedge CLOCK);
    end
    bus.rx_valid = 1'b0;
    @(negedge CLOCK);
    check("done_hold", 64'(done), 64'd1);
    check("done_hold_core", 64'(core_RST_n), 64'd1);

    // reload together with a sync byte: reload wins, byte dropped
    reload       = 1'b1;
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    @(negedge CLOCK);
    reload       = 1'b0;
    bus.rx_valid = 1'b0;
    check("reload_done", 64'(done), 64'd0);
    check("reload_core", 64'(core_RST_n), 64'd0);
    cur_done = 1'b0;

    // Bad checksum, then a good frame straight from ERROR
    q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
    run_frame(q, "badsum");
    q[11] = 8'hB6;
    run_frame(q, "recover");
    do_reload("rl1");

    // Garbage before sync
    q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
          8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
    run_frame(q, "garbage");
    check("garbage_data", 64'(bus.wr_data), 64'h12345678);
    do_reload("rl2");

    // Count boundaries
    q = '{8'hA5, 8'h00, 8'h00};
    run_frame(q, "cnt0");
    q = '{8'hA5, 8'h11, 8'h00};
    run_frame(q, "cnt_depth_p1");
    q = '{8'hA5, 8'h00, 8'h01};
    run_frame(q, "cnt_256");

    // Full-depth load
    make_frame(DEPTH, 0, q);
    run_frame(q, "full");
    check("full_last_addr", 64'(bus.wr_addr), 64'(DEPTH - 1));
    do_reload("rl3");

    // Timeout after the 2nd data byte
    q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    run_frame(q, "timeout");

    // Asynchronous reset mid-DATA (one word already written)
    q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    begin
      bit ed, ee, et;
      model(q, ed, ee, et);
      send(q);
    end
    check("midrst_drain", 64'(exp_q.size()), 64'd0);
    #3;
    RST_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge CLOCK);
    RST_n = 1'b1;
    @(negedge CLOCK);
    cur_done = 1'b0;

    // Random frames
    for (int t = 0; t < 12; t++) begin
      if (cur_done) do_reload("rl_rand");
      n    = $urandom_range(1, 5);
      mode = $urandom_range(0, 7);
      mode = (mode < 5) ? 0 : (mode < 7) ? 1 : 2;
      make_frame(n, mode, q);
      ng = $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        do g = 8'($urandom_range(0, 255)); while (g == 8'hA5);
        q.push_front(g);
      end
      run_frame(q, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_count, err_count);
    $finish;
  end

endmodule
